// File: rtl/mdu_if.sv
// Execute-stage handshake between the hazard/forwarding logic and the multiply/divide unit.
// The master issues requests; the slave reports busy and the HI/LO registers.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, output op, output a, output b,
                    input busy, input hi, input lo);
    modport slave  (input start, input op, input a, input b,
                    output busy, output hi, output lo);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed when the
// request is accepted and held as pending until the busy countdown expires.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    mdu_if.slave bus
);
    localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_pend, w_pend_nxt;
    logic        r_commit, w_commit_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    logic [63:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_sden, w_uden;
    logic [31:0] w_squo_mag, w_srem_mag, w_squo, w_srem, w_uquo, w_urem;
    logic        w_b_zero;

    // Lower 64 bits of the sign-extended product are the exact signed product.
    assign w_a_sx   = {{32{bus.a[31]}}, bus.a};
    assign w_b_sx   = {{32{bus.b[31]}}, bus.b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
    assign w_b_zero   = (bus.b == 32'd0);
    assign w_abs_a    = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b    = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    assign w_sden     = w_b_zero ? 32'd1 : w_abs_b;
    assign w_uden     = w_b_zero ? 32'd1 : bus.b;
    assign w_squo_mag = w_abs_a / w_sden;
    assign w_srem_mag = w_abs_a % w_sden;
    assign w_squo     = (bus.a[31] ^ bus.b[31]) ? (~w_squo_mag + 32'd1) : w_squo_mag;
    assign w_srem     = bus.a[31] ? (~w_srem_mag + 32'd1) : w_srem_mag;
    assign w_uquo     = bus.a / w_uden;
    assign w_urem     = bus.a % w_uden;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_pend   <= 64'd0;
            r_commit <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_commit <= w_commit_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pend_nxt   = r_pend;
        w_commit_nxt = r_commit;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    unique case (bus.op)
                        3'd0, 3'd1: begin
                            w_pend_nxt   = (bus.op == 3'd0) ? w_prod_s : w_prod_u;
                            w_commit_nxt = 1'b1;
                            w_cnt_nxt    = MultCnt;
                            w_state_nxt  = StBusy;
                        end
                        3'd2, 3'd3: begin
                            w_pend_nxt   = (bus.op == 3'd2) ? {w_srem, w_squo} : {w_urem, w_uquo};
                            w_commit_nxt = !w_b_zero;
                            w_cnt_nxt    = DivCnt;
                            w_state_nxt  = StBusy;
                        end
                        3'd4:    w_hi_nxt = bus.a;
                        3'd5:    w_lo_nxt = bus.a;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = StIdle;
                    if (r_commit) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.busy = (r_state == StBusy);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues expected completions and timed snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mdu_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if bus ();

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset_n),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } done_t;

    typedef struct {
        string       name;
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } snap_t;

    done_t done_q[$];
    snap_t snap_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: a falling busy is a completion; snapshots fire on their cycle.
    logic prev_busy = 1'b0;
    int   run = 0;
    always @(negedge clk) begin
        done_t d;
        snap_t s;
        if (bus.busy === 1'b1) begin
            run++;
        end else begin
            if (prev_busy === 1'b1) begin
                if (done_q.size() == 0) begin
                    check32("spurious_done", 32'(run), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check32({d.name, "_len"}, 32'(run), 32'(d.len));
                    check32({d.name, "_hi"}, bus.hi, d.hi);
                    check32({d.name, "_lo"}, bus.lo, d.lo);
                end
            end
            run = 0;
        end
        prev_busy = bus.busy;
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            check32({s.name, "_busy"}, {31'd0, bus.busy}, {31'd0, s.busy});
            check32({s.name, "_hi"}, bus.hi, s.hi);
            check32({s.name, "_lo"}, bus.lo, s.lo);
        end
    end

    task automatic expect_done(input string name, input int len,
                               input logic [31:0] hi, input logic [31:0] lo);
        done_t d;
        d.name = name; d.len = len; d.hi = hi; d.lo = lo;
        done_q.push_back(d);
    endtask

    task automatic expect_snap(input string name, input int at, input logic busy,
                               input logic [31:0] hi, input logic [31:0] lo);
        snap_t s;
        s.name = name; s.cyc = at; s.busy = busy; s.hi = hi; s.lo = lo;
        snap_q.push_back(s);
    endtask

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd7;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_checks++;
            $display("FAIL %s_timeout: busy still high after 40 cycles, expected low", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        expect_snap("reset_state", 2, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        expect_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("mult");
        expect_done("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("multu");

        expect_done("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div");
        expect_done("divu", 10, 32'h0000_0001, 32'h0000_0003);
        issue(3'd3, 32'h0000_0007, 32'h0000_0002);
        wait_idle("divu");

        c = cyc;
        expect_snap("mthi", c + 1, 1'b0, 32'h1234_5678, 32'h0000_0003);
        issue(3'd4, 32'h1234_5678, 32'd0);
        expect_snap("mtlo", c + 2, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);

        issue(3'd4, 32'h0000_0011, 32'd0);
        issue(3'd5, 32'h0000_0022, 32'd0);
        expect_done("divu_by0", 10, 32'h0000_0011, 32'h0000_0022);
        issue(3'd3, 32'h0000_0055, 32'd0);
        wait_idle("divu_by0");

        // Issued in the first idle cycle after divide completion; mtlo pulse mid-window.
        c = cyc;
        expect_done("mult_ign", 5, 32'h0000_0001, 32'h0000_0000);
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.a     = 32'h0000_DEAD;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd7;
        expect_snap("mtlo_ignored", c + 4, 1'b1, 32'h0000_0011, 32'h0000_0022);
        wait_idle("mult_ign");

        expect_done("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        expect_done("divu_100_7", 10, 32'h0000_0002, 32'h0000_000E);
        issue(3'd3, 32'd100, 32'd7);
        wait_idle("divu_100_7");
        expect_done("mult_b2b", 5, 32'h0000_0000, 32'h0000_002A);
        issue(3'd0, 32'd6, 32'd7);
        wait_idle("mult_b2b");

        c = cyc;
        expect_done("div_abort", 3, 32'd0, 32'd0);
        issue(3'd2, 32'd100, 32'd3);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        expect_snap("abort_state", c + 4, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_snap("post_abort", c + 20, 1'b0, 32'd0, 32'd0);
        repeat (20) @(negedge clk);

        check32("done_q_left", 32'(done_q.size()), 32'd0);
        check32("snap_q_left", 32'(snap_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
